// File: rtl/pcie_tlp_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pcie_tlp_req_arbiter
// Description : Round-robin arbiter and tag allocator in front of the PCIe
//               transaction-layer TLP input port. Non-posted requests
//               (MRd, CfgRd, CfgWr) receive the lowest free tag from a pool
//               of NUM_TAGS tags. Posted requests carry tag 0 and use no tag.
//               One registered TLP at a time is presented downstream.
//               Completions return tags to the pool.
//
// Ports       : clk, rst_n          clock, async active-low reset
//               i_req_valid/o_req_ready   per-requester handshake
//               i_req_type/addr/len_dw    packed request fields (req i at i*W)
//               o_tlp_valid/i_tlp_ready   downstream handshake
//               o_tlp_type/addr/len_dw/tag/src  registered downstream fields
//               i_cpl_valid/i_cpl_tag     completion (tag return)
//               o_outstanding             number of tags in use
//               o_err_pulse               one-cycle error flag
//
// Options     : PCIE_ARB_LEN_CHECK_EN - when defined, requests with
//               len_dw == 0 or len_dw > MAX_LEN_DW are consumed and dropped
//               (no tag, no TLP) and flagged on o_err_pulse.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pcie_tlp_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 10,
  parameter int TAG_W      = 8,
  parameter int NUM_TAGS   = 32,
  parameter int MAX_LEN_DW = 128
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic [3*NUM_REQ-1:0]             i_req_type,
  input  logic [ADDR_W*NUM_REQ-1:0]        i_req_addr,
  input  logic [LEN_W*NUM_REQ-1:0]         i_req_len_dw,
  output logic                             o_tlp_valid,
  input  logic                             i_tlp_ready,
  output logic [2:0]                       o_tlp_type,
  output logic [ADDR_W-1:0]                o_tlp_addr,
  output logic [LEN_W-1:0]                 o_tlp_len_dw,
  output logic [TAG_W-1:0]                 o_tlp_tag,
  output logic [$clog2(NUM_REQ)-1:0]       o_tlp_src,
  input  logic                             i_cpl_valid,
  input  logic [TAG_W-1:0]                 i_cpl_tag,
  output logic [$clog2(NUM_TAGS+1)-1:0]    o_outstanding,
  output logic                             o_err_pulse
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(NUM_TAGS+1);

  localparam logic [2:0] c_type_mrd   = 3'd0;
  localparam logic [2:0] c_type_cfgrd = 3'd2;
  localparam logic [2:0] c_type_cfgwr = 3'd3;

  // Elaboration-time parameter sanity check
  if ((NUM_REQ < 2) || (NUM_REQ > 8) || (NUM_TAGS < 2) ||
      (NUM_TAGS > (1 << TAG_W)) || (MAX_LEN_DW < 1)) begin : g_param_check
    $error("pcie_tlp_req_arbiter: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NUM_TAGS-1:0] r_free;       // 1 = tag available
  logic [CNT_W-1:0]    r_outstanding;
  logic [SRC_W-1:0]    r_rr_ptr;
  logic                r_tlp_valid;
  logic [2:0]          r_tlp_type;
  logic [ADDR_W-1:0]   r_tlp_addr;
  logic [LEN_W-1:0]    r_tlp_len_dw;
  logic [TAG_W-1:0]    r_tlp_tag;
  logic [SRC_W-1:0]    r_tlp_src;
  logic                r_err;

  // --------------------------------------------------------------------------
  // Per-requester decode
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_np;
  logic [NUM_REQ-1:0] w_elig;
  logic               w_any_free;

  assign w_any_free = |r_free;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [2:0] w_type;
    assign w_type     = i_req_type[3*gi +: 3];
    assign w_np[gi]   = (w_type == c_type_mrd) | (w_type == c_type_cfgrd) |
                        (w_type == c_type_cfgwr);
    assign w_elig[gi] = i_req_valid[gi] & (~w_np[gi] | w_any_free);
  end

  // --------------------------------------------------------------------------
  // Round-robin grant: eligible requester with the smallest forward distance
  // from r_rr_ptr wins.
  // --------------------------------------------------------------------------
  logic               w_slot_open;
  logic               w_found;
  logic [SRC_W-1:0]   w_gidx;
  logic [NUM_REQ-1:0] w_grant_oh;
  int                 w_best_dist;
  int                 w_dist;

  assign w_slot_open = ~r_tlp_valid | i_tlp_ready;

  always_comb begin
    w_found     = 1'b0;
    w_gidx      = '0;
    w_grant_oh  = '0;
    w_best_dist = NUM_REQ;
    w_dist      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - int'(r_rr_ptr)) % NUM_REQ;
      if (w_elig[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_gidx      = SRC_W'(i);
        w_found     = 1'b1;
        w_grant_oh  = '0;
        w_grant_oh[i] = 1'b1;
      end
    end
  end

  assign o_req_ready = w_grant_oh & {NUM_REQ{w_slot_open}};

  logic w_accept;
  assign w_accept = w_found & w_slot_open;

  logic [SRC_W-1:0] w_rr_next;
  assign w_rr_next = (w_gidx == SRC_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;

  // Field mux for the granted requester
  logic [2:0]        w_sel_type;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LEN_W-1:0]  w_sel_len;
  logic              w_sel_np;

  always_comb begin
    w_sel_type = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    w_sel_np   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gidx == SRC_W'(i)) begin
        w_sel_type = i_req_type[3*i +: 3];
        w_sel_addr = i_req_addr[ADDR_W*i +: ADDR_W];
        w_sel_len  = i_req_len_dw[LEN_W*i +: LEN_W];
        w_sel_np   = w_np[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional length check
  // --------------------------------------------------------------------------
  logic w_len_bad;
`ifdef PCIE_ARB_LEN_CHECK_EN
  assign w_len_bad = (w_sel_len == '0) || (32'(w_sel_len) > 32'(MAX_LEN_DW));
`else
  assign w_len_bad = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Tag pool. Allocation looks only at the registered free map, so a tag
  // returned this cycle becomes allocatable on the next one.
  // --------------------------------------------------------------------------
  logic [NUM_TAGS-1:0] w_low_mask;
  logic [TAG_W-1:0]    w_alloc_tag;
  logic                w_do_alloc;
  logic [NUM_TAGS-1:0] w_alloc_mask;

  always_comb begin
    w_low_mask  = '0;
    w_alloc_tag = '0;
    for (int t = NUM_TAGS-1; t >= 0; t--) begin
      if (r_free[t]) begin
        w_low_mask    = '0;
        w_low_mask[t] = 1'b1;
        w_alloc_tag   = TAG_W'(t);
      end
    end
  end

  assign w_do_alloc   = w_accept & w_sel_np & ~w_len_bad;
  assign w_alloc_mask = w_low_mask & {NUM_TAGS{w_do_alloc}};

  // Completion decode; tags >= NUM_TAGS never match and fall into the error path
  logic [NUM_TAGS-1:0] w_cpl_dec;
  logic                w_cpl_hit;
  logic                w_cpl_err;

  always_comb begin
    w_cpl_dec = '0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      w_cpl_dec[t] = (i_cpl_tag == TAG_W'(t));
    end
  end

  assign w_cpl_hit = i_cpl_valid & (|(w_cpl_dec & ~r_free));
  assign w_cpl_err = i_cpl_valid & ~w_cpl_hit;

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free        <= '1;
      r_outstanding <= '0;
      r_rr_ptr      <= '0;
      r_tlp_valid   <= 1'b0;
      r_tlp_type    <= '0;
      r_tlp_addr    <= '0;
      r_tlp_len_dw  <= '0;
      r_tlp_tag     <= '0;
      r_tlp_src     <= '0;
      r_err         <= 1'b0;
    end else begin
      r_free <= (r_free & ~w_alloc_mask) | (w_cpl_dec & {NUM_TAGS{w_cpl_hit}});

      case ({w_do_alloc, w_cpl_hit})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      r_err <= w_cpl_err | (w_accept & w_len_bad);

      // Dropped (bad-length) requests still advance the pointer
      if (w_accept) begin
        r_rr_ptr <= w_rr_next;
      end

      if (w_accept && !w_len_bad) begin
        r_tlp_valid  <= 1'b1;
        r_tlp_type   <= w_sel_type;
        r_tlp_addr   <= w_sel_addr;
        r_tlp_len_dw <= w_sel_len;
        r_tlp_tag    <= w_sel_np ? w_alloc_tag : '0;
        r_tlp_src    <= w_gidx;
      end else if (w_slot_open) begin
        r_tlp_valid  <= 1'b0;
      end
    end
  end

  assign o_tlp_valid   = r_tlp_valid;
  assign o_tlp_type    = r_tlp_type;
  assign o_tlp_addr    = r_tlp_addr;
  assign o_tlp_len_dw  = r_tlp_len_dw;
  assign o_tlp_tag     = r_tlp_tag;
  assign o_tlp_src     = r_tlp_src;
  assign o_outstanding = r_outstanding;
  assign o_err_pulse   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tlp_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcie_tlp_req_arbiter
// Description : Self-checking bench for pcie_tlp_req_arbiter. A transaction
//               level model (tag set, pointer, output slot) predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcie_tlp_req_arbiter;

  localparam int NR   = 4;
  localparam int AW   = 32;
  localparam int LW   = 10;
  localparam int TW   = 8;
  localparam int NT   = 32;
  localparam int MAXL = 128;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [3*NR-1:0] req_type;
  logic [AW*NR-1:0] req_addr;
  logic [LW*NR-1:0] req_len;
  logic            tlp_valid;
  logic            tlp_ready;
  logic [2:0]      tlp_type;
  logic [AW-1:0]   tlp_addr;
  logic [LW-1:0]   tlp_len;
  logic [TW-1:0]   tlp_tag;
  logic [1:0]      tlp_src;
  logic            cpl_valid;
  logic [TW-1:0]   cpl_tag;
  logic [5:0]      outstanding;
  logic            err_pulse;

  always #5 clk = ~clk;

  pcie_tlp_req_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TAG_W(TW),
    .NUM_TAGS(NT), .MAX_LEN_DW(MAXL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_type(req_type), .i_req_addr(req_addr), .i_req_len_dw(req_len),
    .o_tlp_valid(tlp_valid), .i_tlp_ready(tlp_ready),
    .o_tlp_type(tlp_type), .o_tlp_addr(tlp_addr), .o_tlp_len_dw(tlp_len),
    .o_tlp_tag(tlp_tag), .o_tlp_src(tlp_src),
    .i_cpl_valid(cpl_valid), .i_cpl_tag(cpl_tag),
    .o_outstanding(outstanding), .o_err_pulse(err_pulse)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- model state ----------------
  bit          m_used[NT];
  bit          m_valid;
  logic [2:0]  m_type;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  logic [TW-1:0] m_tag;
  int          m_src;
  int          m_rr;
  bit          m_err;

  function automatic bit is_np(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd2) || (t == 3'd3);
  endfunction

  function automatic bit len_rejected(input logic [LW-1:0] l);
`ifdef PCIE_ARB_LEN_CHECK_EN
    return (l == 0) || (int'(l) > MAXL);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_used[t] = 1'b0;
    m_valid = 0; m_type = 0; m_addr = 0; m_len = 0; m_tag = 0;
    m_src = 0; m_rr = 0; m_err = 0;
  endtask

  task automatic idle();
    req_valid = '0; req_type = '0; req_addr = '0; req_len = '0;
    tlp_ready = 1'b1; cpl_valid = 1'b0; cpl_tag = '0;
  endtask

  // Called at a negedge with inputs already driven: checks all outputs
  // against the model, advances the model across the next posedge, and
  // returns at the following negedge.
  task automatic cycle();
    int nfree, low, g, cnt;
    bit open, hit, drop;
    logic [NR-1:0] exp_rdy;
    logic [2:0] ty;
    #1;
    nfree = 0; low = -1;
    for (int t = 0; t < NT; t++) if (!m_used[t]) begin
      nfree++;
      if (low < 0) low = t;
    end
    cnt = NT - nfree;
    open = !m_valid || tlp_ready;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_rr + k) % NR;
      if (g < 0 && req_valid[i] && (!is_np(req_type[3*i +: 3]) || nfree > 0)) g = i;
    end
    exp_rdy = (open && g >= 0) ? NR'(1 << g) : '0;

    chk("m_req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("m_tlp_valid", 64'(tlp_valid), 64'(m_valid));
    chk("m_outstanding", 64'(outstanding), 64'(cnt));
    chk("m_err_pulse", 64'(err_pulse), 64'(m_err));
    if (m_valid) begin
      chk("m_tlp_type", 64'(tlp_type), 64'(m_type));
      chk("m_tlp_addr", 64'(tlp_addr), 64'(m_addr));
      chk("m_tlp_len", 64'(tlp_len), 64'(m_len));
      chk("m_tlp_tag", 64'(tlp_tag), 64'(m_tag));
      chk("m_tlp_src", 64'(tlp_src), 64'(m_src));
    end

    // next state
    hit  = cpl_valid && (int'(cpl_tag) < NT) && m_used[int'(cpl_tag) % NT];
    drop = 1'b0;
    if (g >= 0 && open) begin
      ty   = req_type[3*g +: 3];
      drop = len_rejected(req_len[LW*g +: LW]);
      m_rr = (g + 1) % NR;
      if (!drop) begin
        m_valid = 1'b1;
        m_type  = ty;
        m_addr  = req_addr[AW*g +: AW];
        m_len   = req_len[LW*g +: LW];
        m_src   = g;
        m_tag   = 0;
        if (is_np(ty)) begin
          m_tag = TW'(low);
          m_used[low] = 1'b1;
        end
      end else begin
        m_valid = 1'b0;
      end
    end else if (open) begin
      m_valid = 1'b0;
    end
    if (hit) m_used[int'(cpl_tag)] = 1'b0;
    m_err = (cpl_valid && !hit) || (g >= 0 && open && drop);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    chk("rst_tlp_valid", 64'(tlp_valid), 0);
    chk("rst_tlp_addr", 64'(tlp_addr), 0);
    chk("rst_tlp_tag", 64'(tlp_tag), 0);
    chk("rst_tlp_src", 64'(tlp_src), 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_err", 64'(err_pulse), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = ($urandom_range(0, 99) < 60);
      req_type[3*i +: 3] = 3'($urandom_range(0, 7));
      req_addr[AW*i +: AW] = $urandom;
      case ($urandom_range(0, 4))
        0: req_len[LW*i +: LW] = LW'(0);
        1: req_len[LW*i +: LW] = LW'(128);
        2: req_len[LW*i +: LW] = LW'(129);
        default: req_len[LW*i +: LW] = LW'($urandom_range(1, 127));
      endcase
    end
    tlp_ready = ($urandom_range(0, 99) < 70);
    cpl_valid = ($urandom_range(0, 99) < 30);
    cpl_tag   = TW'($urandom_range(0, NT - 1));
    if ($urandom_range(0, 9) == 0) cpl_tag = TW'($urandom_range(0, NT + 7));
  endtask

  logic [AW-1:0] held_addr;

  initial begin
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    do_reset();

    // ---- posted round robin ----
    req_valid = 4'b1111;
    req_type  = {3'd1, 3'd1, 3'd1, 3'd1};
    req_addr  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_1000};
    req_len   = {10'd4, 10'd3, 10'd2, 10'd1};
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("rr_src", 64'(tlp_src), 64'(n % 4));
      chk("rr_tag", 64'(tlp_tag), 0);
      chk("rr_valid", 64'(tlp_valid), 1);
    end

    // ---- tag allocation and return ----
    do_reset();
    req_valid = 4'b0100;
    req_type  = {3'd1, 3'd0, 3'd1, 3'd1};
    req_addr  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_1000};
    for (int n = 0; n < 3; n++) begin
      cycle();
      chk("mrd_tag", 64'(tlp_tag), 64'(n));
      chk("mrd_src", 64'(tlp_src), 2);
    end
    chk("mrd_outstanding3", 64'(outstanding), 3);
    req_valid = 4'b0000;
    cpl_valid = 1'b1; cpl_tag = 8'd1;
    cycle();
    chk("cpl_outstanding2", 64'(outstanding), 2);
    cpl_valid = 1'b0;
    req_valid = 4'b0100;
    cycle();
    chk("mrd_reuse_tag1", 64'(tlp_tag), 1);

    // ---- pool exhaustion ----
    do_reset();
    req_valid = 4'b0001;
    req_type  = {3'd1, 3'd1, 3'd1, 3'd0};
    req_addr  = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_1000};
    for (int n = 0; n < NT; n++) cycle();
    chk("full_outstanding", 64'(outstanding), 32);
    req_valid = 4'b0011;
    #1 chk("full_only_posted", 64'(req_ready), 64'(4'b0010));
    cycle();
    chk("full_posted_src", 64'(tlp_src), 1);
    chk("full_posted_tag", 64'(tlp_tag), 0);
    req_valid = 4'b0001;
    cpl_valid = 1'b1; cpl_tag = 8'd5;
    #1 chk("full_no_grant", 64'(req_ready), 0);
    cycle();
    cpl_valid = 1'b0;
    chk("freed_outstanding", 64'(outstanding), 31);
    #1 chk("freed_grant", 64'(req_ready), 64'(4'b0001));
    cycle();
    chk("freed_tag5", 64'(tlp_tag), 5);
    chk("freed_src0", 64'(tlp_src), 0);

    // ---- backpressure ----
    held_addr = tlp_addr;
    tlp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      #1 chk("bp_ready0", 64'(req_ready), 0);
      cycle();
      chk("bp_tag", 64'(tlp_tag), 5);
      chk("bp_addr", 64'(tlp_addr), 64'(held_addr));
      chk("bp_valid", 64'(tlp_valid), 1);
    end
    tlp_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(req_ready), 64'(4'b0010));
    cycle();
    chk("bp_release_src", 64'(tlp_src), 1);

    // ---- spurious completions ----
    do_reset();
    cpl_valid = 1'b1; cpl_tag = 8'd7;
    cycle();
    chk("spur_err", 64'(err_pulse), 1);
    chk("spur_outstanding", 64'(outstanding), 0);
    cpl_tag = 8'd40;
    cycle();
    chk("range_err", 64'(err_pulse), 1);
    cpl_valid = 1'b0;
    cycle();
    chk("err_clear", 64'(err_pulse), 0);

`ifdef PCIE_ARB_LEN_CHECK_EN
    // ---- length check ----
    do_reset();
    req_valid = 4'b0001;
    req_type  = {3'd1, 3'd1, 3'd1, 3'd0};
    req_len   = {10'd1, 10'd1, 10'd1, 10'd0};
    #1 chk("len0_ready", 64'(req_ready), 1);
    cycle();
    chk("len0_novalid", 64'(tlp_valid), 0);
    chk("len0_err", 64'(err_pulse), 1);
    chk("len0_notag", 64'(outstanding), 0);
    req_len = {10'd1, 10'd1, 10'd1, 10'd129};
    cycle();
    chk("len129_novalid", 64'(tlp_valid), 0);
    chk("len129_err", 64'(err_pulse), 1);
    req_len = {10'd1, 10'd1, 10'd1, 10'd128};
    cycle();
    chk("len128_valid", 64'(tlp_valid), 1);
    chk("len128_len", 64'(tlp_len), 128);
    chk("len128_err", 64'(err_pulse), 0);
    chk("len128_tag", 64'(outstanding), 1);
`endif

    // ---- randomized traffic with a mid-run reset ----
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      if (n == 1500) do_reset();
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
